sub4_serial: RTL and testbench
==============================

# sub4_serial

Bit-serial unsigned subtractor, the inverse-operation counterpart of the team's combinational ripple adder. It computes `d = a - b` one bit per clock, LSB first, using a single borrow flip-flop in place of the adder's carry chain. It sits beside the adder in the arithmetic test set. It provides a handshaked, multi-cycle datapath that exercises sequential simulation: FSM, shift registers and a bit counter.

## Interface

- `W`, default 4: operand and result width in bits; legal range is 2 and above.
- `clk` input 1: single clock, rising-edge active.
- `rst` input 1: reset, asynchronous and active-high.
- `start` input 1: request a subtraction; sampled only in IDLE.
- `a` input W: minuend, unsigned; latched on the accepting edge.
- `b` input W: subtrahend, unsigned; latched on the accepting edge.
- `busy` output 1: high while an operation is in progress.
- `done` output 1: one-cycle pulse; `d` and `borrow` are valid from that cycle onward.
- `d` output W: difference `(a - b) mod 2^W`.
- `borrow` output 1: final borrow out, 1 iff `a < b`.

## Operation

- States:
  - IDLE: waiting for `start`.
  - RUN: processing one bit per cycle.
- Internal state:
  - `sa`, `sb`: W-bit operand shift registers, shifted right so bit 0 is processed first.
  - `br`: borrow flip-flop.
  - `acc`: W-bit result shift register; each new bit enters at the MSB and shifts right.
  - `cnt`: bit counter, ceil(log2 W) bits.
- Transition IDLE to RUN on a clock edge where `start` is 1:
  - `sa` <= `a`, `sb` <= `b`, `br` <= 0, `cnt` <= 0.
  - `busy` <= 1.
- Each RUN edge, with `x = sa[0]` and `y = sb[0]`:
  - Difference bit: `x ^ y ^ br`.
  - Next borrow: `(~x & y) | (~x & br) | (y & br)`.
  - Shift `sa`, `sb` and `acc` right by one; `cnt` <= `cnt + 1`.
- Final RUN edge (`cnt == W-1`):
  - `d` <= completed result, i.e. `acc` including this bit.
  - `borrow` <= next borrow.
  - `done` <= 1, `busy` <= 0, state goes to IDLE.
- `done` self-clears on the following edge.
- `d` and `borrow` hold their values until the next completion; they never change mid-operation.
- `start` while in RUN is ignored: no queuing, no restart.
- Changes on `a` or `b` after the accepting edge have no effect.
- Arithmetic is pure modulo 2^W. There is no signed interpretation and no overflow flag beyond `borrow`.

## Timing

- Reset values, applied immediately on `rst` rising, independent of `clk`:
  - State IDLE.
  - `busy`=0, `done`=0, `d`=0, `borrow`=0.
  - `cnt`=0, `br`=0.
- Reset mid-operation aborts the operation: no `done` pulse, and `d` and `borrow` return to 0.
- Start is accepted at edge k.
- `busy` is high from edge k to edge k+W.
- Bits are processed at edges k+1 through k+W.
- `d`, `borrow` and `done` update at edge k+W, so latency is W cycles from the accepting edge.
- `done` is high for exactly the cycle between edges k+W and k+W+1.
- `busy` and `done` are never high together.
- Earliest next acceptance is edge k+W+1, i.e. `start` held high during the `done` cycle. Back-to-back throughput is one result per W+1 cycles.
- `start` held high continuously re-triggers at each IDLE edge, giving one operation per W+1 cycles.
- Release of `rst` is synchronous to the first following edge; `start` must not be sampled on the same edge that `rst` falls.

## Test plan

- Reset, then a=5, b=3, pulse `start` → `busy` for 4 cycles; `done` at edge k+4 with d=2, borrow=0.
- a=3, b=5 → d=14 (4'b1110), borrow=1.
- Wrap and borrow-chain boundaries:
  - a=0, b=1 → d=15, borrow=1, with the borrow propagating through all bits.
  - a=15, b=15 → d=0, borrow=0.
  - a=0, b=0 → d=0, borrow=0.
- Ignored stimulus during an operation:
  - Start a=13, b=7.
  - At cycle 2, change a to 0 and b to 15, and pulse `start`.
  - Required: a single `done` with d=6, borrow=0, and `busy` unaffected.
- Reset mid-operation and recovery:
  - Start a=9, b=2 and assert `rst` at cycle 2.
  - Required: `busy`, `done`, `d` and `borrow` go to 0 immediately, and no `done` appears.
  - After release, a=11, b=4 → d=7.
- Back-to-back and exhaustive:
  - Hold `start` high with a=8, b=1 then a=1, b=8, switching during the first `done` cycle.
  - Required: `done` pulses 5 cycles apart, giving d=7, borrow=0 then d=9, borrow=1.
  - Also sweep all 256 (a, b) pairs against the `a - b` reference model.

Source files
------------

// File: rtl/sub4_serial.sv
// sub4_serial: bit-serial unsigned subtractor, d = (a - b) mod 2^W.
//
// One difference bit is produced per clock, LSB first, using a single borrow
// flip-flop in place of a ripple borrow chain. A started operation takes W
// clock edges; results are registered and held until the next completion.
//
// Ports:
//   clk    - rising-edge clock
//   rst    - asynchronous, active-high reset
//   start  - request a subtraction (sampled only while idle)
//   a, b   - W-bit unsigned minuend / subtrahend, latched on the accepting edge
//   busy   - high while an operation is in progress
//   done   - one-cycle pulse; d and borrow are valid from that cycle onward
//   d      - W-bit difference
//   borrow - final borrow out, 1 iff a < b
//
// Handshake: start acts as "valid" and !busy as "ready". A request is accepted
// on any rising edge where start=1 and the block is idle (busy=0); operands are
// captured on that same edge. start while busy is ignored, never queued.
// Holding start high re-triggers on every idle edge, so the done cycle doubles
// as the earliest acceptance slot (one result per W+1 cycles).

module sub4_serial #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] d,
  output logic         borrow
);

  localparam int CW = $clog2(W);
  localparam logic [CW-1:0] LAST = CW'(W - 1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [W-1:0]  sa;
  logic [W-1:0]  sb;
  logic [W-1:0]  acc;
  logic          br;
  logic [CW-1:0] cnt;

  logic accept;
  logic last;
  logic x;
  logic y;
  logic diff_bit;
  logic br_next;

  // Full-subtractor on the current LSBs and the stored borrow.
  assign x        = sa[0];
  assign y        = sb[0];
  assign diff_bit = x ^ y ^ br;
  assign br_next  = (~x & y) | (~x & br) | (y & br);

  // busy is simply "in RUN": it rises on the accepting edge and falls on the
  // final bit edge, which is also the edge that raises done, so the two can
  // never overlap.
  assign busy = (state_q == RUN);

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    last    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          accept  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        if (cnt == LAST) begin
          last    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sa     <= '0;
      sb     <= '0;
      acc    <= '0;
      br     <= 1'b0;
      cnt    <= '0;
      d      <= '0;
      borrow <= 1'b0;
      done   <= 1'b0;
    end else begin
      done <= last;
      if (accept) begin
        sa  <= a;
        sb  <= b;
        br  <= 1'b0;
        cnt <= '0;
      end else if (state_q == RUN) begin
        sa  <= {1'b0, sa[W-1:1]};
        sb  <= {1'b0, sb[W-1:1]};
        // New bits enter at the MSB; after W shifts the first (LSB) result
        // bit has arrived at bit 0. acc needs no clearing on accept because
        // every stale bit is shifted out before the result is published.
        acc <= {diff_bit, acc[W-1:1]};
        br  <= br_next;
        cnt <= cnt + CW'(1);
        if (last) begin
          d      <= {diff_bit, acc[W-1:1]};
          borrow <= br_next;
        end
      end
    end
  end

endmodule

// File: tb/tb_sub4_serial.sv
// tb_sub4_serial: self-checking bench for sub4_serial (W=4).
//
// A cycle monitor keeps a transaction-level model of the block: it decides
// from the sampled inputs whether each edge accepts a request, pushes the
// arithmetic result (a - b mod 2^W, a < b) onto an expected queue, counts
// down W edges and then expects exactly one done with the queued result.
// Directed sequences from the test plan, a shuffled exhaustive sweep and
// randomized operations drive the inputs.

module tb_sub4_serial;

  localparam int W    = 4;
  localparam int MASK = (1 << W) - 1;

  // ---------------- clock / reset ----------------
  logic         clk    = 1'b0;
  logic         rst    = 1'b1;
  logic         start  = 1'b0;
  logic [W-1:0] a      = '0;
  logic [W-1:0] b      = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] d;
  logic         borrow;

  always #5 clk = ~clk;

  sub4_serial #(.W(W)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .d      (d),
    .borrow (borrow)
  );

  // ---------------- checking ----------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- scoreboard / reference model ----------------
  logic [W:0]   exp_q[$];
  int           model_left = 0;
  logic [W-1:0] held_d     = '0;
  logic         held_b     = 1'b0;
  logic         mon_start;
  logic         mon_rst;
  logic [W-1:0] mon_a;
  logic [W-1:0] mon_b;
  logic         mon_done;
  logic [W:0]   mon_res;

  always @(posedge clk) begin
    // Inputs as sampled by this edge (the bench changes them only #1 later).
    mon_start = start;
    mon_rst   = rst;
    mon_a     = a;
    mon_b     = b;
    mon_done  = 1'b0;
    if (mon_rst) begin
      model_left = 0;
      exp_q.delete();
      held_d = '0;
      held_b = 1'b0;
    end else if (model_left == 0) begin
      if (mon_start) begin
        model_left = W;
        exp_q.push_back({(int'(mon_a) < int'(mon_b)),
                         W'((int'(mon_a) - int'(mon_b)) & MASK)});
      end
    end else begin
      model_left--;
      if (model_left == 0) begin
        mon_done = 1'b1;
        if (exp_q.size() > 0) begin
          mon_res = exp_q.pop_front();
          held_b  = mon_res[W];
          held_d  = mon_res[W-1:0];
        end
      end
    end
    #1;
    chk("mon_busy",   busy,   (model_left != 0));
    chk("mon_done",   done,   mon_done);
    chk("mon_d",      d,      held_d);
    chk("mon_borrow", borrow, held_b);
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Advance until done is seen; n = number of edges waited.
  task automatic wait_done(input string tag, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!done && n < 4 * W);
    chk({tag, "_seen"}, done, 1);
  endtask

  task automatic run_op(input string tag, input int aa, input int bb,
                        input int exp_d, input int exp_b);
    int n;
    a     = W'(aa);
    b     = W'(bb);
    start = 1'b1;
    tick();
    start = 1'b0;
    // Post-acceptance operand changes must not matter.
    a = W'($urandom);
    b = W'($urandom);
    wait_done(tag, n);
    chk({tag, "_lat"}, n, W);
    chk({tag, "_d"}, d, exp_d);
    chk({tag, "_bw"}, borrow, exp_b);
    tick();
    chk({tag, "_pulse"}, done, 0);
  endtask

  // ---------------- stimulus ----------------
  int order[256];
  int n;
  int aa;
  int bb;

  initial begin
    // Reset
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_d", d, 0);
    chk("rst_bw", borrow, 0);
    #4 rst = 1'b0;
    tick();

    // Basic and boundary operations
    run_op("5m3",   5,  3,  2, 0);
    run_op("3m5",   3,  5, 14, 1);
    run_op("0m1",   0,  1, 15, 1);
    run_op("15m15", 15, 15, 0, 0);
    run_op("0m0",   0,  0,  0, 0);

    // start and operand changes during RUN are ignored
    a = 13; b = 7; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    a = 0; b = 15; start = 1'b1;
    tick();
    start = 1'b0;
    wait_done("ign", n);
    chk("ign_d", d, 6);
    chk("ign_bw", borrow, 0);
    repeat (W + 2) tick();
    chk("ign_d_hold", d, 6);

    // Reset mid-operation
    a = 9; b = 2; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_d", d, 0);
    chk("mid_rst_bw", borrow, 0);
    @(posedge clk);
    #1;
    #4 rst = 1'b0;
    repeat (W + 2) tick();
    run_op("11m4", 11, 4, 7, 0);

    // Back-to-back with start held high
    a = 8; b = 1; start = 1'b1;
    wait_done("b2b1", n);
    chk("b2b1_d", d, 7);
    chk("b2b1_bw", borrow, 0);
    a = 1; b = 8;
    wait_done("b2b2", n);
    chk("b2b_gap", n, W + 1);
    chk("b2b2_d", d, 9);
    chk("b2b2_bw", borrow, 1);
    start = 1'b0;
    tick();

    // Exhaustive sweep in shuffled order, back-to-back
    for (int i = 0; i < 256; i++) order[i] = i;
    for (int i = 255; i > 0; i--) begin
      int j;
      int t;
      j = $urandom_range(0, i);
      t = order[i];
      order[i] = order[j];
      order[j] = t;
    end
    start = 1'b1;
    for (int k = 0; k < 256; k++) begin
      aa = (order[k] >> W) & MASK;
      bb = order[k] & MASK;
      a  = W'(aa);
      b  = W'(bb);
      wait_done("sweep", n);
      chk("sweep_gap", n, W + 1);
      chk("sweep_d", d, (aa - bb) & MASK);
      chk("sweep_bw", borrow, (aa < bb));
    end
    start = 1'b0;
    tick();

    // Randomized operations with random idle gaps
    for (int k = 0; k < 40; k++) begin
      aa = $urandom_range(0, MASK);
      bb = $urandom_range(0, MASK);
      run_op("rnd", aa, bb, (aa - bb) & MASK, (aa < bb));
      repeat ($urandom_range(0, 2)) tick();
    end

    repeat (3) tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
